// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: FSM state encoding, RV32I
// funct3 width/sign codes, the data-memory word-address width, and a helper
// that flags funct3 codes with no meaning for the given access direction.
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam int MEM_AW = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only have B/H/W; loads additionally have BU/HU.
    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        logic bad;
        if (we) bad = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        else    bad = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational lane logic for byte/halfword/word accesses.
//   word       : 32-bit memory word (read data)
//   offset     : byte offset within the word (addr[1:0])
//   funct3     : RV32I width/sign code
//   wdata      : LSB-aligned store data
//   load_val   : selected lane, sign- or zero-extended
//   merged     : word with the store lane replaced by wdata (SW: wdata)
//   misaligned : halfword on odd address or word on non-zero offset
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged,
    output logic        misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[7:0];
        case (offset)
            2'd0: byte_lane = word[7:0];
            2'd1: byte_lane = word[15:8];
            2'd2: byte_lane = word[23:16];
            2'd3: byte_lane = word[31:24];
            default: byte_lane = word[7:0];
        endcase
        half_lane = offset[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_val = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   load_val = {24'd0, byte_lane};
            F3_H:    load_val = {{16{half_lane[15]}}, half_lane};
            F3_HU:   load_val = {16'd0, half_lane};
            default: load_val = word;
        endcase

        // funct3[1:0] is the access width for both loads and stores.
        merged     = word;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                case (offset)
                    2'd0: merged[7:0]   = wdata[7:0];
                    2'd1: merged[15:8]  = wdata[7:0];
                    2'd2: merged[23:16] = wdata[7:0];
                    2'd3: merged[31:24] = wdata[7:0];
                    default: merged = word;
                endcase
            end
            2'b01: begin
                if (offset[1]) merged[31:16] = wdata[15:0];
                else           merged[15:0]  = wdata[15:0];
                misaligned = offset[0];
            end
            2'b10: begin
                merged     = wdata;
                misaligned = (offset != 2'd0);
            end
            default: begin
                merged     = word;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Single-outstanding RV32I load/store unit in front of a word-wide data
// memory with combinational read. Sub-word stores are read-modify-write.
//   clk, rst (async, active-low)
//   req_valid/req_ready : request handshake; a request is taken on a clock
//                         edge where both are high. req_ready is high only in
//                         IDLE, so requests presented while busy are simply
//                         not taken (never queued).
//   req_we, req_funct3, req_addr, req_wdata : request fields
//   rsp_valid (1-cycle pulse), rsp_rdata, rsp_err : completion, no backpressure
//   mem_wr_en, mem_address, mem_wr_data, mem_rd_data : data memory port
//   dbg_state : current FSM state
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_wr_en,
    output logic [MEM_AW-1:0] mem_address,
    output logic [31:0]       mem_wr_data,
    input  logic [31:0]       mem_rd_data,
    output logic [1:0]        dbg_state
);

    state_t      state_q, state_n;
    logic [11:0] addr_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [31:0] rd_word_q;
    logic        err_q;

    logic        idle;
    logic        accept;
    logic        req_err;
    logic [1:0]  align_offset;
    logic [2:0]  align_funct3;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic        misaligned;

    // Upper address bits alias onto the 4 KiB memory and are dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:12];

    assign idle   = (state_q == IDLE);
    assign accept = idle && req_valid;

    // In IDLE the aligner checks the incoming request for misalignment;
    // afterwards it works on the captured request.
    assign align_offset = idle ? req_addr[1:0] : addr_q[1:0];
    assign align_funct3 = idle ? req_funct3    : funct3_q;

    lsu_align u_align (
        .word       (rd_word_q),
        .offset     (align_offset),
        .funct3     (align_funct3),
        .wdata      (wdata_q),
        .load_val   (load_val),
        .merged     (merged),
        .misaligned (misaligned)
    );

    assign req_err = is_illegal(req_we, req_funct3) || misaligned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            funct3_q  <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rd_word_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_n;
            if (accept) begin
                addr_q   <= req_addr[11:0];
                funct3_q <= req_funct3;
                we_q     <= req_we;
                wdata_q  <= req_wdata;
                err_q    <= req_err;
            end
            if (state_q == RD) rd_word_q <= mem_rd_data;
        end
    end

    always_comb begin
        state_n     = state_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        rsp_rdata   = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        mem_address = addr_q[11:2];
        dbg_state   = state_q;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)                  state_n = RESP;
                    else if (!req_we)             state_n = RD;
                    else if (req_funct3 == F3_W)  state_n = WR;
                    else                          state_n = RD;
                end
            end
            RD: begin
                state_n = we_q ? WR : RESP;
            end
            WR: begin
                mem_wr_en   = 1'b1;
                mem_wr_data = merged;
                state_n     = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                if (!we_q && !err_q) rsp_rdata = load_val;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with a behavioural data memory. Drivers
// push expected responses/writes into queues; negedge monitors pop and compare.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_wr_en;
    logic [9:0]  mem_address;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic [1:0]  dbg_state;

    load_store_unit dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .mem_wr_en   (mem_wr_en),
        .mem_address (mem_address),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .dbg_state   (dbg_state)
    );

    // clock / memory / cycle counter
    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    assign mem_rd_data = mem[mem_address];
    always @(posedge clk) if (mem_wr_en) mem[mem_address] <= mem_wr_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    int          exp_lat_q[$];
    int          exp_acc_q[$];
    logic [31:0] wexp_q[$];
    logic [9:0]  waddr_q[$];
    int errors = 0;
    int checks = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check32("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    logic [31:0] e;
                    logic        ee;
                    int          lat, acc;
                    e = exp_q.pop_front(); ee = exp_err_q.pop_front();
                    lat = exp_lat_q.pop_front(); acc = exp_acc_q.pop_front();
                    check32("rsp_rdata", rsp_rdata, e);
                    check32("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
                    check32("rsp_latency", cyc - acc + 1, lat);
                end
            end
            if (mem_wr_en) begin
                if (wexp_q.size() == 0) begin
                    check32("unexpected_write", 32'd1, 32'd0);
                end else begin
                    check32("wr_address", {22'd0, mem_address}, {22'd0, waddr_q.pop_front()});
                    check32("wr_data", mem_wr_data, wexp_q.pop_front());
                end
            end
        end
    end

    // drivers
    task automatic push_wr(input logic [9:0] a, input logic [31:0] d);
        waddr_q.push_back(a);
        wexp_q.push_back(d);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) check32("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err, input int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        wait_ready();
        exp_q.push_back(exp_rd); exp_err_q.push_back(exp_err);
        exp_lat_q.push_back(lat); exp_acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    initial begin
        int acc1, acc2, busy, n;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[20] = 32'h1234_5678;

        // reset values
        #12;
        check32("rst_ready", {31'd0, req_ready}, 32'd1);
        check32("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check32("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check32("rst_rsp_rdata", rsp_rdata, 32'd0);
        check32("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check32("rst_mem_address", {22'd0, mem_address}, 32'd0);
        check32("rst_mem_wr_data", mem_wr_data, 32'd0);
        @(negedge clk); rst = 1'b1;

        // SW, then loads of each width
        push_wr(10'd10, 32'hDEAD_BEEF);
        issue(1'b1, F3_W,  32'h28, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        issue(1'b0, F3_B,  32'h2B, 32'h0, 32'hFFFF_FFDE, 1'b0, 2);
        issue(1'b0, F3_BU, 32'h2B, 32'h0, 32'h0000_00DE, 1'b0, 2);
        issue(1'b0, F3_H,  32'h28, 32'h0, 32'hFFFF_BEEF, 1'b0, 2);
        issue(1'b0, F3_W,  32'h28, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
        // SB read-modify-write
        push_wr(10'd10, 32'hDEAD_55EF);
        issue(1'b1, F3_B,  32'h29, 32'h0000_0055, 32'h0, 1'b0, 3);
        issue(1'b0, F3_HU, 32'h2A, 32'h0, 32'h0000_DEAD, 1'b0, 2);
        issue(1'b0, F3_H,  32'h2A, 32'h0, 32'hFFFF_DEAD, 1'b0, 2);
        issue(1'b0, F3_B,  32'h29, 32'h0, 32'h0000_0055, 1'b0, 2);
        issue(1'b0, F3_B,  32'h28, 32'h0, 32'hFFFF_FFEF, 1'b0, 2);
        issue(1'b0, F3_W,  32'h1028, 32'h0, 32'hDEAD_55EF, 1'b0, 2);
        // SH upper half, SB top-of-word-lane 0
        push_wr(10'd11, 32'h1234_0000);
        issue(1'b1, F3_H,  32'h2E, 32'hFFFF_1234, 32'h0, 1'b0, 3);
        issue(1'b0, F3_W,  32'h2C, 32'h0, 32'h1234_0000, 1'b0, 2);
        push_wr(10'd11, 32'h1234_0080);
        issue(1'b1, F3_B,  32'h2C, 32'h0000_0080, 32'h0, 1'b0, 3);
        issue(1'b0, F3_BU, 32'h2C, 32'h0, 32'h0000_0080, 1'b0, 2);
        issue(1'b0, F3_B,  32'h2C, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
        // misaligned / illegal: no memory access, rdata 0
        issue(1'b0, F3_W,  32'h2A, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b1, F3_H,  32'h29, 32'h0000_1111, 32'h0, 1'b1, 1);
        issue(1'b0, F3_HU, 32'h2B, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b0, 3'b011, 32'h28, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b1, 3'b011, 32'h28, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b1, F3_W,  32'h2D, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b0, F3_W,  32'h28, 32'h0, 32'hDEAD_55EF, 1'b0, 2);

        // req_valid held across two loads
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h2C; req_wdata = 32'h0;
        wait_ready();
        acc1 = cyc + 1;
        exp_q.push_back(32'h1234_0080); exp_err_q.push_back(1'b0);
        exp_lat_q.push_back(2); exp_acc_q.push_back(acc1);
        @(posedge clk);
        #1 req_funct3 = F3_B; req_addr = 32'h2B;
        busy = 0;
        @(negedge clk);
        while (!req_ready && busy < 20) begin busy++; @(negedge clk); end
        acc2 = cyc + 1;
        exp_q.push_back(32'hFFFF_FFDE); exp_err_q.push_back(1'b0);
        exp_lat_q.push_back(2); exp_acc_q.push_back(acc2);
        check32("busy_cycles", busy, 2);
        check32("second_accept_gap", acc2 - acc1, 3);
        @(posedge clk);
        #1 req_valid = 1'b0;

        // reset during the WR cycle of an SH
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_H; req_addr = 32'h50; req_wdata = 32'h0000_ABCD;
        wait_ready();
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 check32("abort_in_wr", {31'd0, mem_wr_en}, 32'd1);
        rst = 1'b0;
        #1;
        check32("abort_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check32("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check32("abort_mem_address", {22'd0, mem_address}, 32'd0);
        check32("abort_mem_wr_data", mem_wr_data, 32'd0);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        check32("abort_mem20", mem[20], 32'h1234_5678);
        check32("abort_ready", {31'd0, req_ready}, 32'd1);

        // one more load after recovery
        issue(1'b0, F3_W, 32'h50, 32'h0, 32'h1234_5678, 1'b0, 2);

        n = 0;
        while ((exp_q.size() != 0 || wexp_q.size() != 0) && n < 50) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        check32("rsp_queue_empty", exp_q.size(), 32'd0);
        check32("wr_queue_empty", wexp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
